joy_serial_rx: RTL and testbench



---
 rtl/joy_serial_rx.sv | 205 ++++++++++++++++++++
 tb/tb_joy_serial_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_rx.sv
// Serial joystick receiver for chained 74165 pads: loads, shifts and latches PLAYERS*BITS buttons per frame.
// Optional JOY_SERIAL_DEBOUNCE_EN: a pad field only updates after two identical consecutive frames.
module joy_serial_rx #(
   parameter int PLAYERS    = 2,
   parameter int BITS       = 12,
   parameter int CLK_DIV    = 20,
   parameter int LOAD_TICKS = 2,
   parameter int GAP_TICKS  = 8
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      ser_data,
   output logic                      ser_clk,
   output logic                      ser_load_n,
   output logic [PLAYERS*BITS-1:0]   joy_out,
   output logic [PLAYERS-1:0]        disconnected,
   output logic                      frame_valid,
   output logic                      busy
);

   localparam int NBITS  = PLAYERS * BITS;
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int IDX_W  = $clog2(NBITS);
   localparam int TMAX   = (LOAD_TICKS > GAP_TICKS) ? LOAD_TICKS : GAP_TICKS;
   localparam int TCNT_W = $clog2(TMAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

   state_t              r_state, w_state_next;
   logic [DIV_W-1:0]    r_div;
   logic [TCNT_W-1:0]   r_tcnt, w_tcnt_next;
   logic [IDX_W-1:0]    r_idx, w_idx_next;
   logic                r_phase, w_phase_next;
   logic                r_ser_clk, w_ser_clk_next;
   logic                r_load_n, w_load_n_next;
   logic                r_sync1, r_sync2;
   logic [NBITS-1:0]    r_shreg;
   logic [NBITS-1:0]    r_joy;
   logic [PLAYERS-1:0]  r_disc;
   logic                r_fv;
   logic                w_tick, w_sample, w_latch;
   logic [NBITS-1:0]    w_dec_joy;
   logic [PLAYERS-1:0]  w_dec_disc;
   logic [PLAYERS-1:0]  w_upd;

   assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_div   <= '0;
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
         r_sync1 <= ser_data;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_tcnt_next    = r_tcnt;
      w_idx_next     = r_idx;
      w_phase_next   = r_phase;
      w_ser_clk_next = r_ser_clk;
      w_load_n_next  = r_load_n;
      w_sample       = 1'b0;
      w_latch        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_tick && enable) begin
               w_state_next  = ST_LOAD;
               w_load_n_next = 1'b0;
               w_tcnt_next   = '0;
            end
         end
         ST_LOAD: begin
            if (w_tick) begin
               if (r_tcnt == TCNT_W'(LOAD_TICKS - 1)) begin
                  w_state_next  = ST_SHIFT;
                  w_load_n_next = 1'b1;
                  w_idx_next    = '0;
                  w_phase_next  = 1'b0;
               end else begin
                  w_tcnt_next = r_tcnt + TCNT_W'(1);
               end
            end
         end
         ST_SHIFT: begin
            // Even tick samples and raises ser_clk; odd tick lowers it and advances.
            if (w_tick) begin
               if (!r_phase) begin
                  w_sample       = 1'b1;
                  w_ser_clk_next = 1'b1;
                  w_phase_next   = 1'b1;
               end else begin
                  w_ser_clk_next = 1'b0;
                  w_phase_next   = 1'b0;
                  if (r_idx == IDX_W'(NBITS - 1)) begin
                     w_state_next = ST_GAP;
                     w_tcnt_next  = '0;
                     w_latch      = 1'b1;
                  end else begin
                     w_idx_next = r_idx + IDX_W'(1);
                  end
               end
            end
         end
         ST_GAP: begin
            if (w_tick) begin
               if (r_tcnt == TCNT_W'(GAP_TICKS - 1)) begin
                  if (enable) begin
                     w_state_next  = ST_LOAD;
                     w_load_n_next = 1'b0;
                     w_tcnt_next   = '0;
                  end else begin
                     w_state_next = ST_IDLE;
                  end
               end else begin
                  w_tcnt_next = r_tcnt + TCNT_W'(1);
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // A pad whose every bit read as pressed is treated as unplugged.
   generate
      for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_pad
         assign w_dec_disc[gi]             = &r_shreg[gi*BITS +: BITS];
         assign w_dec_joy[gi*BITS +: BITS] = w_dec_disc[gi] ? '0 : r_shreg[gi*BITS +: BITS];
      end
   endgenerate

`ifdef JOY_SERIAL_DEBOUNCE_EN
   logic [NBITS-1:0]   r_prev_joy;
   logic [PLAYERS-1:0] r_prev_disc;
   logic               r_prev_valid;

   generate
      for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_deb
         assign w_upd[gi] = r_prev_valid
                          && (w_dec_joy[gi*BITS +: BITS] == r_prev_joy[gi*BITS +: BITS])
                          && (w_dec_disc[gi] == r_prev_disc[gi]);
      end
   endgenerate

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_prev_joy   <= '0;
         r_prev_disc  <= '0;
         r_prev_valid <= 1'b0;
      end else if (w_latch) begin
         r_prev_joy   <= w_dec_joy;
         r_prev_disc  <= w_dec_disc;
         r_prev_valid <= 1'b1;
      end
   end
`else
   assign w_upd = '1;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_tcnt    <= '0;
         r_idx     <= '0;
         r_phase   <= 1'b0;
         r_ser_clk <= 1'b0;
         r_load_n  <= 1'b1;
         r_shreg   <= '0;
         r_joy     <= '0;
         r_disc    <= '0;
         r_fv      <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_tcnt    <= w_tcnt_next;
         r_idx     <= w_idx_next;
         r_phase   <= w_phase_next;
         r_ser_clk <= w_ser_clk_next;
         r_load_n  <= w_load_n_next;
         r_fv      <= w_latch;
         if (w_sample)
            r_shreg[r_idx] <= ~r_sync2;
         if (w_latch) begin
            for (int p = 0; p < PLAYERS; p++) begin
               if (w_upd[p]) begin
                  r_joy[p*BITS +: BITS] <= w_dec_joy[p*BITS +: BITS];
                  r_disc[p]             <= w_dec_disc[p];
               end
            end
         end
      end
   end

   assign ser_clk      = r_ser_clk;
   assign ser_load_n   = r_load_n;
   assign joy_out      = r_joy;
   assign disconnected = r_disc;
   assign frame_valid  = r_fv;
   assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_joy_serial_rx.sv
// Directed bench for joy_serial_rx with a behavioural 74165 chain model.
module tb_joy_serial_rx;
   localparam int PLAYERS    = 2;
   localparam int BITS       = 12;
   localparam int CLK_DIV    = 20;
   localparam int LOAD_TICKS = 2;
   localparam int GAP_TICKS  = 8;
   localparam int N          = PLAYERS * BITS;
   localparam int PERIOD     = (LOAD_TICKS + 2*N + GAP_TICKS) * CLK_DIV;
   localparam int LAT_MIN    = (LOAD_TICKS + 2*N) * CLK_DIV + 1;
   localparam int LAT_MAX    = (LOAD_TICKS + 2*N + 1) * CLK_DIV;
   localparam int NV         = 6;
`ifdef JOY_SERIAL_DEBOUNCE_EN
   localparam int REP = 2;
`else
   localparam int REP = 1;
`endif

   logic clk_sys = 1'b0;
   logic reset, enable, ser_data, ser_clk, ser_load_n, frame_valid, busy;
   logic [N-1:0]       joy_out;
   logic [PLAYERS-1:0] disconnected;
   logic [BITS-1:0]    pad0_raw, pad1_raw;
   logic [N-1:0]       chain_sh = '1;
   logic               sclk_d = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc = 0, fv_cyc = 0, rises = 0, lows = 0;
   int last_period = 0, last_rises = 0, last_low = 0;
   int cyc_w, k, viol;

   typedef struct {
      logic [BITS-1:0] p0;
      logic [BITS-1:0] p1;
      logic [N-1:0]    joy;
      logic [1:0]      disc;
   } vec_t;
   vec_t vecs [NV];

   always #5 clk_sys = ~clk_sys;

   joy_serial_rx #(
      .PLAYERS(PLAYERS), .BITS(BITS), .CLK_DIV(CLK_DIV),
      .LOAD_TICKS(LOAD_TICKS), .GAP_TICKS(GAP_TICKS)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .enable(enable), .ser_data(ser_data),
      .ser_clk(ser_clk), .ser_load_n(ser_load_n), .joy_out(joy_out),
      .disconnected(disconnected), .frame_valid(frame_valid), .busy(busy)
   );

   // Chain: parallel load while ser_load_n low, shift toward ser_data after each ser_clk rise.
   always @(posedge clk_sys) begin
      if (ser_load_n === 1'b0)
         chain_sh <= {pad1_raw, pad0_raw};
      else if (ser_clk === 1'b1 && sclk_d === 1'b0)
         chain_sh <= {1'b1, chain_sh[N-1:1]};
   end
   assign ser_data = chain_sh[0];

   // Per-frame activity, snapshotted on each frame_valid pulse.
   always @(posedge clk_sys) begin
      cyc    <= cyc + 1;
      sclk_d <= ser_clk;
      if (frame_valid === 1'b1) begin
         last_period <= cyc - fv_cyc;
         fv_cyc      <= cyc;
         last_rises  <= rises;
         last_low    <= lows;
         rises       <= 0;
         lows        <= 0;
      end else begin
         rises <= rises + ((ser_clk === 1'b1 && sclk_d === 1'b0) ? 1 : 0);
         lows  <= lows + ((ser_load_n === 1'b0) ? 1 : 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic wait_fv(input int limit, output int cycles);
      cycles = 0;
      while (cycles < limit) begin
         @(posedge clk_sys); #1;
         cycles++;
         if (frame_valid === 1'b1) return;
      end
      total++;
      bad++;
      $display("FAIL frame_valid_timeout: got none within %0d cycles expected a pulse", limit);
   endtask

   initial begin
      vecs[0] = '{12'hFFE, 12'hFFF, 24'h000001, 2'b00};
      vecs[1] = '{12'hFFF, 12'h000, 24'h000000, 2'b10};
      vecs[2] = '{12'h000, 12'hFFF, 24'h000000, 2'b01};
      vecs[3] = '{12'h5A5, 12'h0F0, 24'hF0FA5A, 2'b00};
      vecs[4] = '{12'h000, 12'h000, 24'h000000, 2'b11};
      vecs[5] = '{12'h7FF, 12'hFFE, 24'h001800, 2'b00};

      reset = 1'b1; enable = 1'b0; pad0_raw = '1; pad1_raw = '1;
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      chk("rst_joy", 32'(joy_out), 32'h0);
      chk("rst_disc", 32'(disconnected), 32'h0);
      chk("rst_fv", 32'(frame_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ser_clk", 32'(ser_clk), 32'h0);
      chk("rst_load_n", 32'(ser_load_n), 32'h1);

      for (int i = 0; i < NV; i++) begin
         for (int r = 0; r < REP; r++) begin
            pad0_raw = vecs[i].p0;
            pad1_raw = vecs[i].p1;
            if (i == 0 && r == 0) enable = 1'b1;
            wait_fv(PERIOD + CLK_DIV + 10, cyc_w);
            if (i == 0 && r == 0)
               chk("first_latency_in_range", 32'(cyc_w >= LAT_MIN && cyc_w <= LAT_MAX), 32'h1);
            if (r == REP - 1) begin
               chk($sformatf("vec%0d_joy", i), 32'(joy_out), 32'(vecs[i].joy));
               chk($sformatf("vec%0d_disc", i), 32'(disconnected), 32'(vecs[i].disc));
            end
            @(posedge clk_sys); #1;
            if (!(i == 0 && r == 0)) begin
               chk($sformatf("vec%0d_period", i), 32'(last_period), 32'(PERIOD));
               chk($sformatf("vec%0d_clk_rises", i), 32'(last_rises), 32'(N));
               chk($sformatf("vec%0d_load_low", i), 32'(last_low), 32'(LOAD_TICKS * CLK_DIV));
            end
         end
      end

      // enable dropped while shifting bit 10: frame still completes, then idle.
      k = 0;
      while (rises != 11 && k < PERIOD) begin @(posedge clk_sys); #1; k++; end
      chk("drop_at_bit10", 32'(rises), 32'd11);
      enable = 1'b0;
      wait_fv(PERIOD, cyc_w);
      chk("drop_frame_joy", 32'(joy_out), 32'(vecs[NV-1].joy));
      k = 0;
      while (busy !== 1'b0 && k < GAP_TICKS * CLK_DIV + 10) begin @(posedge clk_sys); #1; k++; end
      chk("drop_busy_low", 32'(busy), 32'h0);
      viol = 0;
      repeat (3 * PERIOD) begin
         @(posedge clk_sys); #1;
         if (busy !== 1'b0 || ser_clk !== 1'b0 || ser_load_n !== 1'b1 || frame_valid !== 1'b0) viol++;
      end
      chk("idle_quiet_violations", 32'(viol), 32'h0);
      chk("idle_joy_hold", 32'(joy_out), 32'(vecs[NV-1].joy));

      // reset pulsed mid-shift discards the frame.
      pad0_raw = 12'h5A5; pad1_raw = 12'h0F0;
      enable = 1'b1;
      k = 0;
      while (rises != 5 && k < 2 * PERIOD) begin @(posedge clk_sys); #1; k++; end
      chk("midrst_at_bit4", 32'(rises), 32'd5);
      reset = 1'b1;
      @(posedge clk_sys); #1;
      chk("midrst_joy", 32'(joy_out), 32'h0);
      chk("midrst_disc", 32'(disconnected), 32'h0);
      chk("midrst_ser_clk", 32'(ser_clk), 32'h0);
      chk("midrst_load_n", 32'(ser_load_n), 32'h1);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_fv", 32'(frame_valid), 32'h0);
      reset = 1'b0;
      viol = 0;
      repeat (200) begin
         @(posedge clk_sys); #1;
         if (frame_valid !== 1'b0) viol++;
      end
      chk("midrst_no_pulse", 32'(viol), 32'h0);
      wait_fv(PERIOD + CLK_DIV + 10, cyc_w);
`ifdef JOY_SERIAL_DEBOUNCE_EN
      chk("after_rst_joy", 32'(joy_out), 32'h0);
`else
      chk("after_rst_joy", 32'(joy_out), 32'hF0FA5A);
`endif

`ifdef JOY_SERIAL_DEBOUNCE_EN
      pad1_raw = 12'hFFF;
      for (int f = 0; f < 4; f++) begin
         pad0_raw = (f % 2 == 0) ? 12'hFFE : 12'hFFD;
         wait_fv(PERIOD + 10, cyc_w);
         chk($sformatf("deb_alt%0d_pad0", f), 32'(joy_out[BITS-1:0]), 32'h0);
      end
      pad0_raw = 12'hFFD;
      wait_fv(PERIOD + 10, cyc_w);
      wait_fv(PERIOD + 10, cyc_w);
      chk("deb_stable_pad0", 32'(joy_out[BITS-1:0]), 32'h002);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
